reg_scoreboard: RTL and testbench
=================================

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001: Parameter NREG, default 32, number of architectural integer registers; x0 included.
REQ-002: Parameter TAGW, default 3, width of the producer tag tracked per register.
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: rst  input  1  asynchronous, active-high reset.
REQ-005: rs1, rs2  input  5 each  source register addresses from instruction decode.
REQ-006: rs1_valid, rs2_valid  output  1 each  operand ready (no pending producer, or bypassed this cycle).
REQ-007: rs1_data, rs2_data  output  32 each  operand value (register file or bypass).
REQ-008: issue_valid  input  1  decode dispatched an instruction that writes issue_rd.
REQ-009: issue_rd  input  5  destination register of the dispatched instruction.
REQ-010: issue_tag  input  TAGW  producer tag assigned by dispatch.
REQ-011: wb0_valid, wb1_valid  input  1 each  writeback strobes from execute units.
REQ-012: wb0_rd, wb1_rd  input  5 each  writeback destinations.
REQ-013: wb0_tag, wb1_tag  input  TAGW each  producer tags of the writebacks.
REQ-014: wb0_data, wb1_data  input  32 each  writeback values.
REQ-015: flush  input  1  jump redirect; discards all pending producers.
REQ-016: busy_cnt  output  6  number of registers currently marked busy.

Function
REQ-017: State: 32x32 register array, per-register busy bit, per-register TAGW-bit owner tag.
REQ-018: x0 reads 0 with valid=1; issue or writeback to x0 is ignored (no busy, no write).
REQ-019: Read path combinational: rsN_valid = !busy[rsN] or bypass hit; rsN_data = bypass data if hit, else array[rsN].
REQ-020: Bypass hit: wbK_valid, wbK_rd==rsN, wbK_tag==tag[rsN], busy[rsN]; if both ports hit, wb1 wins.
REQ-021: Writeback writes wbK_data into array[wbK_rd] on the clock edge, regardless of tag match.
REQ-022: Writeback clears busy[wbK_rd] only when wbK_tag equals tag[wbK_rd]; stale tags leave busy set.
REQ-023: Both ports writing the same rd in one cycle: wb1 data written; busy cleared if either tag matches.
REQ-024: Issue sets busy[issue_rd]=1 and tag[issue_rd]=issue_tag on the clock edge; visible to reads next cycle.
REQ-025: Issue and matching writeback to the same rd in one cycle: writeback data written, issue wins (busy=1, new tag).
REQ-026: Read of issue_rd in the issue cycle returns the pre-issue state (no self-dependence).
REQ-027: flush clears all busy bits at the edge; register data and same-cycle writeback data still written; a same-cycle issue is dropped.
REQ-028: busy_cnt is a registered population count of busy bits, updated the cycle after busy changes (one-cycle latency).
REQ-029: Writeback to a non-busy register writes data and leaves busy=0.

Reset
REQ-030: On rst assertion, immediately and asynchronously: all busy bits 0, all tags 0, all registers 0, busy_cnt 0.
REQ-031: During rst all inputs ignored; rsN_valid=1 and rsN_data=0 for any address.
REQ-032: Reset asserted mid-operation discards pending producers; first edge after deassertion behaves as from power-up.

Verification
REQ-033: Reset, then read rs1=5, rs2=0 -> rs1_valid=1, rs1_data=0, rs2_valid=1, rs2_data=0, busy_cnt=0.
REQ-034: Issue rd=5 tag=2; next cycle read rs1=5 -> rs1_valid=0; wb0 rd=5 tag=2 data=0xDEADBEEF same cycle -> rs1_valid=1, rs1_data=0xDEADBEEF (bypass); following cycle busy=0, array holds value.
REQ-035: Issue rd=7 tag=1, then rd=7 tag=3; wb0 rd=7 tag=1 data=0x11 -> rd 7 stays busy, array=0x11; wb1 rd=7 tag=3 data=0x22 -> busy cleared, read returns 0x22.
REQ-036: Same cycle: issue rd=9 tag=4 and wb0 rd=9 tag=0 (matching old tag) data=0x55 -> after edge busy[9]=1, tag=4, array[9]=0x55.
REQ-037: Issue rd=1,2,3 on successive cycles -> busy_cnt 1,2,3 one cycle after each; assert flush -> busy_cnt=0 next cycle, reads of 1..3 valid.
REQ-038: Issue rd=0 and wb0 rd=0 data=0xFFFFFFFF -> x0 reads 0 and valid, busy_cnt unchanged.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Register scoreboard: integer register file with per-register busy/tag tracking,
// two writeback ports with operand bypass, flush and a registered busy count.
module reg_scoreboard #(
    parameter int unsigned NREG = 32,
    parameter int unsigned TAGW = 3
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [4:0]      rs1_i,
    input  logic [4:0]      rs2_i,
    output logic            rs1_valid_o,
    output logic            rs2_valid_o,
    output logic [31:0]     rs1_data_o,
    output logic [31:0]     rs2_data_o,
    input  logic            issue_valid_i,
    input  logic [4:0]      issue_rd_i,
    input  logic [TAGW-1:0] issue_tag_i,
    input  logic            wb0_valid_i,
    input  logic [4:0]      wb0_rd_i,
    input  logic [TAGW-1:0] wb0_tag_i,
    input  logic [31:0]     wb0_data_i,
    input  logic            wb1_valid_i,
    input  logic [4:0]      wb1_rd_i,
    input  logic [TAGW-1:0] wb1_tag_i,
    input  logic [31:0]     wb1_data_i,
    input  logic            flush_i,
    output logic [5:0]      busy_cnt_o
);

    logic [31:0]     regs_q [NREG];
    logic [31:0]     regs_d [NREG];
    logic [TAGW-1:0] tag_q  [NREG];
    logic [TAGW-1:0] tag_d  [NREG];
    logic [NREG-1:0] busy_q, busy_d;
    logic [5:0]      cnt_q, cnt_d;

    logic [4:0]  rs     [2];
    logic [1:0]  rd_valid;
    logic [31:0] rd_data [2];

    assign rs[0] = rs1_i;
    assign rs[1] = rs2_i;

    // Read ports: a writeback only bypasses when it is the producer the register waits on.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            logic hit0, hit1;
            hit0 = wb0_valid_i && (wb0_rd_i == rs[p]) && (wb0_tag_i == tag_q[rs[p]])
                   && busy_q[rs[p]];
            hit1 = wb1_valid_i && (wb1_rd_i == rs[p]) && (wb1_tag_i == tag_q[rs[p]])
                   && busy_q[rs[p]];
            rd_valid[p] = 1'b1;
            rd_data[p]  = regs_q[rs[p]];
            if (rs[p] == 5'd0) begin
                rd_data[p] = '0;
            end else if (hit1) begin
                rd_data[p] = wb1_data_i;
            end else if (hit0) begin
                rd_data[p] = wb0_data_i;
            end else begin
                rd_valid[p] = !busy_q[rs[p]];
            end
        end
    end

    assign rs1_valid_o = rd_valid[0];
    assign rs2_valid_o = rd_valid[1];
    assign rs1_data_o  = rd_data[0];
    assign rs2_data_o  = rd_data[1];

    // Entry 0 is never written, so x0 stays zero and never busy.
    always_comb begin
        regs_d = regs_q;
        tag_d  = tag_q;
        busy_d = busy_q;
        for (int i = 1; i < NREG; i++) begin
            logic wr0, wr1, clr, iss;
            wr0 = wb0_valid_i && (wb0_rd_i == 5'(i));
            wr1 = wb1_valid_i && (wb1_rd_i == 5'(i));
            iss = issue_valid_i && (issue_rd_i == 5'(i));
            clr = (wr0 && (wb0_tag_i == tag_q[i])) || (wr1 && (wb1_tag_i == tag_q[i]));
            if (wr0) regs_d[i] = wb0_data_i;
            if (wr1) regs_d[i] = wb1_data_i;
            if (flush_i) begin
                busy_d[i] = 1'b0;
            end else if (iss) begin
                busy_d[i] = 1'b1;
                tag_d[i]  = issue_tag_i;
            end else if (clr) begin
                busy_d[i] = 1'b0;
            end
        end
    end

    // Count reflects the busy bits held during the previous cycle.
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt_d = cnt_d + 6'(busy_q[i]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            regs_q <= '{default: '0};
            tag_q  <= '{default: '0};
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            regs_q <= regs_d;
            tag_q  <= tag_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_cnt_o = cnt_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed stimulus, a per-cycle reference model and
// hand-computed literal expectations.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1, rs2;
    logic        rs1_valid, rs2_valid;
    logic [31:0] rs1_data, rs2_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [2:0]  issue_tag;
    logic        wb0_valid, wb1_valid;
    logic [4:0]  wb0_rd, wb1_rd;
    logic [2:0]  wb0_tag, wb1_tag;
    logic [31:0] wb0_data, wb1_data;
    logic        flush;
    logic [5:0]  busy_cnt;

    int checks = 0;
    int errors = 0;

    reg_scoreboard #(.NREG(32), .TAGW(3)) dut (
        .clk_i(clk), .rst_i(rst),
        .rs1_i(rs1), .rs2_i(rs2),
        .rs1_valid_o(rs1_valid), .rs2_valid_o(rs2_valid),
        .rs1_data_o(rs1_data), .rs2_data_o(rs2_data),
        .issue_valid_i(issue_valid), .issue_rd_i(issue_rd), .issue_tag_i(issue_tag),
        .wb0_valid_i(wb0_valid), .wb0_rd_i(wb0_rd), .wb0_tag_i(wb0_tag), .wb0_data_i(wb0_data),
        .wb1_valid_i(wb1_valid), .wb1_rd_i(wb1_rd), .wb1_tag_i(wb1_tag), .wb1_data_i(wb1_data),
        .flush_i(flush), .busy_cnt_o(busy_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [31:0] m_regs [32];
    logic [2:0]  m_tag  [32];
    logic [31:0] m_busy;
    int          m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_regs <= '{default: '0};
            m_tag  <= '{default: '0};
            m_busy <= '0;
            m_cnt  <= 0;
        end else begin
            logic [31:0] nr [32];
            logic [2:0]  nt [32];
            logic [31:0] nb;
            nr = m_regs;
            nt = m_tag;
            nb = m_busy;
            m_cnt <= $countones(m_busy);
            if (wb0_valid && wb0_rd != 0) begin
                nr[wb0_rd] = wb0_data;
                if (wb0_tag == m_tag[wb0_rd]) nb[wb0_rd] = 1'b0;
            end
            if (wb1_valid && wb1_rd != 0) begin
                nr[wb1_rd] = wb1_data;
                if (wb1_tag == m_tag[wb1_rd]) nb[wb1_rd] = 1'b0;
            end
            if (flush) begin
                nb = '0;
            end else if (issue_valid && issue_rd != 0) begin
                nb[issue_rd] = 1'b1;
                nt[issue_rd] = issue_tag;
            end
            m_regs <= nr;
            m_tag  <= nt;
            m_busy <= nb;
        end
    end

    function automatic logic [32:0] exp_read(input logic [4:0] a);
        if (a == 0) return {1'b1, 32'h0};
        if (!m_busy[a]) return {1'b1, m_regs[a]};
        if (wb1_valid && wb1_rd == a && wb1_tag == m_tag[a]) return {1'b1, wb1_data};
        if (wb0_valid && wb0_rd == a && wb0_tag == m_tag[a]) return {1'b1, wb0_data};
        return {1'b0, m_regs[a]};
    endfunction

    always @(negedge clk) begin
        logic [32:0] e1, e2;
        e1 = exp_read(rs1);
        e2 = exp_read(rs2);
        chk("model_rs1_valid", 32'(rs1_valid), 32'(e1[32]));
        chk("model_rs1_data", rs1_data, e1[31:0]);
        chk("model_rs2_valid", 32'(rs2_valid), 32'(e2[32]));
        chk("model_rs2_data", rs2_data, e2[31:0]);
        chk("model_busy_cnt", 32'(busy_cnt), 32'(m_cnt));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; issue_rd = 0; issue_tag = 0;
        wb0_valid = 0; wb0_rd = 0; wb0_tag = 0; wb0_data = 0;
        wb1_valid = 0; wb1_rd = 0; wb1_tag = 0; wb1_data = 0;
        flush = 0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [2:0] tag);
        issue_valid = 1; issue_rd = rd; issue_tag = tag;
    endtask

    task automatic wb0(input logic [4:0] rd, input logic [2:0] tag, input logic [31:0] d);
        wb0_valid = 1; wb0_rd = rd; wb0_tag = tag; wb0_data = d;
    endtask

    task automatic wb1(input logic [4:0] rd, input logic [2:0] tag, input logic [31:0] d);
        wb1_valid = 1; wb1_rd = rd; wb1_tag = tag; wb1_data = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1; idle(); rs1 = 5; rs2 = 0;
        issue(5, 1); wb0(5, 0, 32'hCAFE);
        tick(); tick();
        chk("in_reset_rs1_valid", 32'(rs1_valid), 32'd1);
        chk("in_reset_rs1_data", rs1_data, 32'h0);
        rst = 0; idle();
        #1;
        chk("post_reset_rs1_valid", 32'(rs1_valid), 32'd1);
        chk("post_reset_rs1_data", rs1_data, 32'h0);
        chk("post_reset_rs2_valid", 32'(rs2_valid), 32'd1);
        chk("post_reset_rs2_data", rs2_data, 32'h0);
        chk("post_reset_busy_cnt", 32'(busy_cnt), 32'd0);

        // Issue, then bypass from the matching producer.
        tick(); issue(5, 2); rs1 = 5;
        #1 chk("issue_cycle_no_self_dep", 32'(rs1_valid), 32'd1);
        tick(); idle(); rs1 = 5;
        #1 chk("busy_after_issue", 32'(rs1_valid), 32'd0);
        chk("cnt_latency", 32'(busy_cnt), 32'd0);
        wb0(5, 2, 32'hDEADBEEF);
        #1 chk("bypass_valid", 32'(rs1_valid), 32'd1);
        chk("bypass_data", rs1_data, 32'hDEADBEEF);
        tick(); idle();
        #1 chk("written_valid", 32'(rs1_valid), 32'd1);
        chk("written_data", rs1_data, 32'hDEADBEEF);
        chk("cnt_one", 32'(busy_cnt), 32'd1);
        tick();
        chk("cnt_back_zero", 32'(busy_cnt), 32'd0);

        // Stale tag writes data but keeps busy.
        issue(7, 1); tick(); issue(7, 3); tick(); idle(); rs1 = 7;
        wb0(7, 1, 32'h11);
        #1 chk("stale_no_bypass", 32'(rs1_valid), 32'd0);
        tick(); idle();
        #1 chk("stale_still_busy", 32'(rs1_valid), 32'd0);
        chk("stale_data_written", rs1_data, 32'h11);
        chk("stale_cnt", 32'(busy_cnt), 32'd1);
        wb1(7, 3, 32'h22);
        #1 chk("wb1_bypass", rs1_data, 32'h22);
        tick(); idle();
        #1 chk("wb1_cleared", 32'(rs1_valid), 32'd1);
        chk("wb1_data", rs1_data, 32'h22);

        // Issue and writeback to same register in one cycle: issue wins.
        issue(9, 4); wb0(9, 0, 32'h55); rs1 = 9;
        #1 chk("pre_issue_read", 32'(rs1_valid), 32'd1);
        tick(); idle();
        #1 chk("issue_wins_busy", 32'(rs1_valid), 32'd0);
        chk("issue_wins_data", rs1_data, 32'h55);
        wb0(9, 0, 32'h66);
        #1 chk("old_tag_no_bypass", 32'(rs1_valid), 32'd0);
        tick(); idle();
        #1 chk("old_tag_data", rs1_data, 32'h66);
        wb0(9, 4, 32'h77);
        #1 chk("new_tag_bypass", rs1_data, 32'h77);
        tick(); idle();

        // Busy count ramp and flush.
        issue(1, 1); tick(); issue(2, 2); tick();
        chk("cnt_ramp1", 32'(busy_cnt), 32'd1);
        issue(3, 3); tick();
        chk("cnt_ramp2", 32'(busy_cnt), 32'd2);
        idle(); flush = 1; issue(4, 5); wb0(2, 7, 32'hAB); rs1 = 1; rs2 = 3;
        #1 chk("flush_cycle_busy", 32'(rs1_valid), 32'd0);
        tick(); idle(); rs1 = 1; rs2 = 2;
        #1 chk("cnt_ramp3", 32'(busy_cnt), 32'd3);
        chk("flush_rs1_valid", 32'(rs1_valid), 32'd1);
        chk("flush_rs2_valid", 32'(rs2_valid), 32'd1);
        chk("flush_wb_data", rs2_data, 32'hAB);
        tick(); rs1 = 4; rs2 = 3;
        #1 chk("cnt_after_flush", 32'(busy_cnt), 32'd0);
        chk("flush_drops_issue", 32'(rs1_valid), 32'd1);

        // x0 ignores issue and writeback.
        issue(0, 1); wb0(0, 0, 32'hFFFFFFFF); rs1 = 0;
        tick(); idle();
        #1 chk("x0_valid", 32'(rs1_valid), 32'd1);
        chk("x0_data", rs1_data, 32'h0);
        tick();
        chk("x0_cnt", 32'(busy_cnt), 32'd0);

        // Both ports to one register: wb1 data, clear on either match.
        issue(10, 5); tick(); idle();
        wb0(10, 5, 32'h1); wb1(10, 6, 32'h2); rs1 = 10;
        #1 chk("wb0_only_hit", rs1_data, 32'h1);
        tick(); idle();
        #1 chk("dual_clear", 32'(rs1_valid), 32'd1);
        chk("dual_wb1_data", rs1_data, 32'h2);
        issue(11, 1); tick(); idle();
        wb0(11, 1, 32'hA); wb1(11, 1, 32'hB); rs1 = 11; rs2 = 11;
        #1 chk("both_hit_rs1", rs1_data, 32'hB);
        chk("both_hit_rs2", rs2_data, 32'hB);
        tick(); idle();

        // Writeback to a register that is not busy.
        wb0(12, 3, 32'h33); rs1 = 12;
        #1 chk("nonbusy_no_bypass", rs1_data, 32'h0);
        tick(); idle();
        #1 chk("nonbusy_written", rs1_data, 32'h33);
        chk("nonbusy_valid", 32'(rs1_valid), 32'd1);

        // Asynchronous reset mid-operation.
        issue(13, 2); tick(); idle(); rs1 = 13; rs2 = 5;
        #1 chk("pre_rst_busy", 32'(rs1_valid), 32'd0);
        rst = 1;
        #1 chk("async_rst_valid", 32'(rs1_valid), 32'd1);
        chk("async_rst_rs1_data", rs1_data, 32'h0);
        chk("async_rst_rs2_data", rs2_data, 32'h0);
        chk("async_rst_cnt", 32'(busy_cnt), 32'd0);
        tick(); tick();
        rst = 0;
        #1 chk("post_rst_valid", 32'(rs1_valid), 32'd1);
        issue(13, 1); tick(); idle();
        #1 chk("post_rst_issue", 32'(rs1_valid), 32'd0);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
